// File: rtl/universal_shift_register.sv
// universal_shift_register
//   Parametrised datapath register with parallel load, logical/rotate/arithmetic
//   shifts, clear, serial taps on both ends, and a burst engine that applies
//   one shift operation N times per start request.
//
// Ports:
//   clk         system clock, all state changes on rising edge
//   reset       synchronous active-low reset
//   enable      qualifies single steps and burst steps
//   mode        operation select (hold/load/shl/shr/rol/ror/asr/clear)
//   D           parallel load data
//   sin_left    serial bit entering at MSB on logical right shift
//   sin_right   serial bit entering at LSB on logical left shift
//   start       burst request, sampled only in IDLE
//   amount      burst step count, latched with start
//   Q           register contents
//   sout_left   Q[WIDTH-1]
//   sout_right  Q[0]
//   busy        burst in progress
//   done        one-cycle pulse after the last burst step
//
// state | meaning
// IDLE  | single-step operation under enable; accepts burst start
// BUSY  | burst running, one step of bmode per enabled edge
// DONE  | one-cycle done pulse, inputs ignored, then back to IDLE

module universal_shift_register #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] D,
    input  logic             sin_left,
    input  logic             sin_right,
    input  logic             start,
    input  logic [CNT_W-1:0] amount,
    output logic [WIDTH-1:0] Q,
    output logic             sout_left,
    output logic             sout_right,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [2:0]       bmode, bmode_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [WIDTH-1:0] q_next;
    logic             burst_mode;

    function automatic logic [WIDTH-1:0] apply_op(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] q,
        input logic [WIDTH-1:0] din,
        input logic             sl,
        input logic             sr
    );
        logic [WIDTH-1:0] r;
        case (op)
            3'b000:  r = q;
            3'b001:  r = din;
            3'b010:  r = {q[WIDTH-2:0], sr};
            3'b011:  r = {sl, q[WIDTH-1:1]};
            3'b100:  r = {q[WIDTH-2:0], q[WIDTH-1]};
            3'b101:  r = {q[0], q[WIDTH-1:1]};
            3'b110:  r = {q[WIDTH-1], q[WIDTH-1:1]};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Only the shift/rotate ops make sense repeated; hold/load/clear never burst.
    assign burst_mode = (mode >= 3'b010) && (mode <= 3'b110);

    always_comb begin
        state_next = state;
        q_next     = Q;
        bmode_next = bmode;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (start && burst_mode) begin
                    bmode_next = mode;
                    cnt_next   = amount;
                    state_next = (amount == '0) ? DONE : BUSY;
                end else if (enable) begin
                    q_next = apply_op(mode, Q, D, sin_left, sin_right);
                end
            end
            BUSY: begin
                if (enable) begin
                    q_next   = apply_op(bmode, Q, D, sin_left, sin_right);
                    cnt_next = cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            Q     <= '0;
            bmode <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            Q     <= q_next;
            bmode <= bmode_next;
            cnt   <= cnt_next;
            // Flags are registered from the next state so they line up with it.
            busy  <= (state_next == BUSY);
            done  <= (state_next == DONE);
        end
    end

    assign sout_left  = Q[WIDTH-1];
    assign sout_right = Q[0];

endmodule

// File: tb/tb_universal_shift_register.sv
module tb_universal_shift_register;

    localparam int W  = 8;
    localparam int CW = 4;
    localparam int M  = 256;
    localparam int H  = 128;

    logic          clk;
    logic          reset;
    logic          enable;
    logic [2:0]    mode;
    logic [W-1:0]  D;
    logic          sin_left;
    logic          sin_right;
    logic          start;
    logic [CW-1:0] amount;
    logic [W-1:0]  Q;
    logic          sout_left;
    logic          sout_right;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    // reference model state
    int mq;
    int remaining;
    int m_bmode;
    bit m_busy;
    bit m_done;

    universal_shift_register #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .mode       (mode),
        .D          (D),
        .sin_left   (sin_left),
        .sin_right  (sin_right),
        .start      (start),
        .amount     (amount),
        .Q          (Q),
        .sout_left  (sout_left),
        .sout_right (sout_right),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Value of the register after one operation, written as plain integer arithmetic.
    function automatic int op_ref(int op, int q, int din, int sl, int sr);
        case (op)
            0:       return q;
            1:       return din;
            2:       return (q * 2 + sr) % M;
            3:       return q / 2 + sl * H;
            4:       return (q * 2) % M + q / H;
            5:       return q / 2 + (q % 2) * H;
            6:       return q / 2 + (q / H) * H;
            default: return 0;
        endcase
    endfunction

    function automatic void model_edge();
        if (!reset) begin
            mq = 0; remaining = 0; m_bmode = 0; m_busy = 0; m_done = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_busy) begin
            if (enable) begin
                mq = op_ref(m_bmode, mq, int'(D), int'(sin_left), int'(sin_right));
                remaining--;
                if (remaining == 0) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end
        end else if (start && mode >= 3'd2 && mode <= 3'd6) begin
            m_bmode = int'(mode);
            if (amount == 0) m_done = 1;
            else begin
                remaining = int'(amount);
                m_busy = 1;
            end
        end else if (enable) begin
            mq = op_ref(int'(mode), mq, int'(D), int'(sin_left), int'(sin_right));
        end
    endfunction

    // One clock: model consumes current inputs, DUT sampled 1 ns after the edge.
    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        check("q",    32'(Q),          32'(mq));
        check("busy", 32'(busy),       32'(m_busy));
        check("done", 32'(done),       32'(m_done));
        check("soutl", 32'(sout_left), 32'(mq / H));
        check("soutr", 32'(sout_right), 32'(mq % 2));
    endtask

    task automatic drive(input bit rst, input bit en, input int md, input int d,
                         input bit st, input int amt);
        reset  = rst;
        enable = en;
        mode   = 3'(md);
        D      = W'(d);
        start  = st;
        amount = CW'(amt);
    endtask

    initial begin
        mq = 0; remaining = 0; m_bmode = 0; m_busy = 0; m_done = 0;
        sin_left = 1'b0; sin_right = 1'b0;
        drive(0, 1, 1, 'hFF, 0, 0);
        @(negedge clk);

        // 1. reset, then load
        cycle();
        check("t1_rst_q", 32'(Q), 32'h00);
        drive(1, 1, 1, 'hAA, 0, 0);
        cycle();
        check("t1_load", 32'(Q), 32'hAA);

        // 2. enable gating, shifts
        drive(1, 0, 1, 'hCC, 0, 0);
        cycle();
        check("t2_hold", 32'(Q), 32'hAA);
        sin_right = 1'b1;
        drive(1, 1, 2, 0, 0, 0);
        cycle();
        check("t2_shl", 32'(Q), 32'h55);
        sin_left = 1'b0;
        drive(1, 1, 3, 0, 0, 0);
        cycle();
        check("t2_shr", 32'(Q), 32'h2A);
        check("t2_soutr", 32'(sout_right), 32'h0);

        // 3. burst rotate right by 3
        drive(1, 1, 1, 'h81, 0, 0);
        cycle();
        drive(1, 1, 5, 0, 1, 3);
        cycle();
        check("t3_start_busy", 32'(busy), 32'h1);
        check("t3_start_q", 32'(Q), 32'h81);
        start = 1'b0;
        cycle();
        check("t3_s1", 32'(Q), 32'hC0);
        cycle();
        check("t3_s2", 32'(Q), 32'h60);
        cycle();
        check("t3_s3", 32'(Q), 32'h30);
        check("t3_done", 32'(done), 32'h1);
        check("t3_busy_low", 32'(busy), 32'h0);
        cycle();
        check("t3_done_clr", 32'(done), 32'h0);

        // 4. arithmetic shift burst with pause
        drive(1, 1, 1, 'h80, 0, 0);
        cycle();
        drive(1, 1, 6, 0, 1, 2);
        cycle();
        start = 1'b0;
        cycle();
        check("t4_s1", 32'(Q), 32'hC0);
        enable = 1'b0;
        cycle();
        cycle();
        check("t4_pause_q", 32'(Q), 32'hC0);
        check("t4_pause_busy", 32'(busy), 32'h1);
        enable = 1'b1;
        cycle();
        check("t4_s2", 32'(Q), 32'hE0);
        check("t4_done", 32'(done), 32'h1);
        cycle();

        // 5. amount=0 burst, start with load mode
        drive(1, 1, 2, 0, 1, 0);
        cycle();
        check("t5_zero_done", 32'(done), 32'h1);
        check("t5_zero_busy", 32'(busy), 32'h0);
        check("t5_zero_q", 32'(Q), 32'hE0);
        drive(1, 0, 0, 0, 0, 0);
        cycle();
        drive(1, 1, 1, 'h5A, 1, 3);
        cycle();
        check("t5_load_q", 32'(Q), 32'h5A);
        check("t5_load_busy", 32'(busy), 32'h0);

        // 6. reset mid-burst, then a normal burst
        drive(1, 1, 1, 'h01, 0, 0);
        cycle();
        drive(1, 1, 4, 0, 1, 5);
        cycle();
        start = 1'b0;
        cycle();
        cycle();
        check("t6_s2", 32'(Q), 32'h04);
        reset = 1'b0;
        cycle();
        check("t6_rst_q", 32'(Q), 32'h00);
        check("t6_rst_busy", 32'(busy), 32'h0);
        drive(1, 0, 0, 0, 0, 0);
        cycle();
        check("t6_no_done", 32'(done), 32'h0);
        drive(1, 1, 1, 'h03, 0, 0);
        cycle();
        drive(1, 1, 4, 0, 1, 2);
        cycle();
        start = 1'b0;
        cycle();
        cycle();
        check("t6_burst2_q", 32'(Q), 32'h0C);
        check("t6_burst2_done", 32'(done), 32'h1);
        cycle();

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 99) != 0);
            enable    = ($urandom_range(0, 3) != 0);
            mode      = 3'($urandom_range(0, 7));
            D         = W'($urandom);
            sin_left  = 1'($urandom_range(0, 1));
            sin_right = 1'($urandom_range(0, 1));
            start     = ($urandom_range(0, 4) == 0);
            amount    = CW'($urandom_range(0, 15));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
